// File: rtl/tag_arb_pkg.sv
// Shared types, SoC address-map defaults and address helpers for the tag-memory arbiter.
// The map constants mirror the ariane_soc values the arbiter is normally built against.
package tag_arb_pkg;

  localparam logic [63:0] DRAMBase          = 64'h0000_0000_8000_0000;
  localparam logic [63:0] DRAMLength        = 64'h0000_0000_4000_0000;
  localparam logic [63:0] TagCacheMemLength = 64'h0000_0000_0001_0000;
  localparam logic [63:0] TagCacheMemBase   = DRAMBase + DRAMLength - TagCacheMemLength;

  localparam int TagGranuleShift   = 4;   // one tag bit per 16-byte granule
  localparam int TagWordCoverShift = 10;  // one 64-bit tag word per 1 KiB
  localparam int CoveredShift      = 3 + TagGranuleShift;  // covered bytes = tag bytes * 128

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ERR} arb_state_e;

  typedef struct packed {
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
    logic [7:0]  be;
  } mem_req_t;

  function automatic logic [63:0] tag_addr_f(input logic [63:0] addr,
                                             input logic [63:0] data_base,
                                             input logic [63:0] tag_base);
    logic [63:0] off;
    off = addr - data_base;
    return tag_base + ((off >> TagWordCoverShift) << 3);
  endfunction

  // The tag store itself sits in DRAM but is never tag-covered.
  function automatic logic in_range_f(input logic [63:0] addr,
                                      input logic [63:0] data_base,
                                      input logic [63:0] tag_base,
                                      input logic [63:0] tag_len);
    logic lo_ok, hi_ok, in_tag;
    lo_ok  = addr >= data_base;
    hi_ok  = (addr - data_base) < (tag_len << CoveredShift);
    in_tag = (addr >= tag_base) && ((addr - tag_base) < tag_len);
    return lo_ok && hi_ok && !in_tag;
  endfunction

endpackage

// File: rtl/tag_mem_arbiter_rr_pick.sv
// Combinational round-robin selector: first valid requester strictly after ptr, wrapping.
module rr_pick #(
  parameter int NumReq = 2
) (
  input  logic [NumReq-1:0]         valid,
  input  logic [$clog2(NumReq)-1:0] ptr,
  output logic [NumReq-1:0]         gnt,
  output logic [$clog2(NumReq)-1:0] idx,
  output logic                      any
);
  localparam int IdxW = $clog2(NumReq);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int i = 1; i <= NumReq; i++) begin
      j = int'(ptr) + i;
      if (j >= NumReq) j = j - NumReq;
      if (!any && valid[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IdxW'(j);
      end
    end
  end

endmodule

// File: rtl/tag_mem_arbiter.sv
// Round-robin arbiter sharing the CHERI tag-memory port, one transaction outstanding.
// Optional TAG_ARB_PERF_CNT_EN adds saturating grant/error counters.
module tag_mem_arbiter
  import tag_arb_pkg::*;
#(
  parameter int          NumReq    = 2,
  parameter logic [63:0] TagBase   = TagCacheMemBase,
  parameter logic [63:0] TagLength = TagCacheMemLength,
  parameter logic [63:0] DataBase  = DRAMBase
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NumReq-1:0]        req_valid_i,
  output logic [NumReq-1:0]        req_ready_o,
  input  logic [NumReq-1:0][63:0]  req_addr_i,
  input  logic [NumReq-1:0]        req_we_i,
  input  logic [NumReq-1:0][63:0]  req_wdata_i,
  input  logic [NumReq-1:0][7:0]   req_be_i,
  output logic [NumReq-1:0]        rsp_valid_o,
  output logic [63:0]              rsp_rdata_o,
  output logic                     rsp_err_o,
  output logic                     mem_req_o,
  input  logic                     mem_gnt_i,
  output logic [63:0]              mem_addr_o,
  output logic                     mem_we_o,
  output logic [63:0]              mem_wdata_o,
  output logic [7:0]               mem_be_o,
  input  logic                     mem_rvalid_i,
  input  logic [63:0]              mem_rdata_i
`ifdef TAG_ARB_PERF_CNT_EN
  ,
  output logic [NumReq-1:0][31:0]  grant_cnt_o,
  output logic [31:0]              err_cnt_o
`endif
);
  localparam int IdxW = $clog2(NumReq);

  arb_state_e        state;
  logic [IdxW-1:0]   ptr, gidx;
  mem_req_t          cap;
  logic              mem_req_q;

  logic [NumReq-1:0] pick_gnt;
  logic [IdxW-1:0]   pick_idx;
  logic              pick_any;
  logic              accept, rsp_mem, rsp_err;
  logic [63:0]       sel_addr;
  logic [NumReq-1:0] gsel;

  rr_pick #(.NumReq(NumReq)) u_pick (
    .valid (req_valid_i),
    .ptr   (ptr),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign sel_addr = req_addr_i[pick_idx];
  assign accept   = rst_ni && (state == IDLE) && pick_any;
  assign gsel     = NumReq'(1) << gidx;

  // Response sideband is combinational so rvalid turns into a same-cycle response.
  assign rsp_mem  = rst_ni && mem_rvalid_i &&
                    ((state == WAIT) || ((state == ISSUE) && mem_gnt_i));
  assign rsp_err  = rst_ni && (state == ERR);

  assign req_ready_o = accept ? pick_gnt : '0;
  assign rsp_valid_o = (rsp_mem || rsp_err) ? gsel : '0;
  assign rsp_err_o   = rsp_err;
  assign rsp_rdata_o = rsp_mem ? mem_rdata_i : '0;

  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = cap.addr;
  assign mem_we_o    = cap.we;
  assign mem_wdata_o = cap.wdata;
  assign mem_be_o    = cap.be;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state     <= IDLE;
      ptr       <= IdxW'(NumReq - 1);
      gidx      <= '0;
      cap       <= '0;
      mem_req_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pick_any) begin
          ptr       <= pick_idx;
          gidx      <= pick_idx;
          cap.addr  <= tag_addr_f(sel_addr, DataBase, TagBase);
          cap.we    <= req_we_i[pick_idx];
          cap.wdata <= req_wdata_i[pick_idx];
          cap.be    <= req_be_i[pick_idx];
          if (in_range_f(sel_addr, DataBase, TagBase, TagLength)) begin
            state     <= ISSUE;
            mem_req_q <= 1'b1;
          end else begin
            state <= ERR;
          end
        end
        ISSUE: if (mem_gnt_i) begin
          mem_req_q <= 1'b0;
          state     <= mem_rvalid_i ? IDLE : WAIT;
        end
        WAIT: if (mem_rvalid_i) state <= IDLE;
        ERR:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TAG_ARB_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      grant_cnt_o <= '0;
      err_cnt_o   <= '0;
    end else begin
      if (accept && (grant_cnt_o[pick_idx] != '1))
        grant_cnt_o[pick_idx] <= grant_cnt_o[pick_idx] + 32'd1;
      if ((state == ERR) && (err_cnt_o != '1))
        err_cnt_o <= err_cnt_o + 32'd1;
    end
  end
`endif

  // A response with no transaction in flight is dropped; flag it in simulation.
  unsolicited_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_rvalid_i |-> ((state == WAIT) || (state == ISSUE)))
    else $warning("tag_mem_arbiter: unsolicited mem_rvalid_i ignored");

endmodule

// File: tb/tb_tag_mem_arbiter.sv
// Self-checking bench for tag_mem_arbiter: directed scenarios plus randomized traffic
// checked against an address-map / round-robin reference model.
module tb_tag_mem_arbiter;
  localparam int N = 2;
  localparam logic [63:0] DB = 64'h8000_0000;
  localparam logic [63:0] TB = 64'hBFFF_0000;
  localparam logic [63:0] TL = 64'h1_0000;

  logic                clk_i = 1'b0;
  logic                rst_ni = 1'b0;
  logic [N-1:0]        req_valid_i = '0;
  logic [N-1:0]        req_ready_o;
  logic [N-1:0][63:0]  req_addr_i = '0;
  logic [N-1:0]        req_we_i = '0;
  logic [N-1:0][63:0]  req_wdata_i = '0;
  logic [N-1:0][7:0]   req_be_i = '0;
  logic [N-1:0]        rsp_valid_o;
  logic [63:0]         rsp_rdata_o;
  logic                rsp_err_o;
  logic                mem_req_o;
  logic                mem_gnt_i = 1'b0;
  logic [63:0]         mem_addr_o;
  logic                mem_we_o;
  logic [63:0]         mem_wdata_o;
  logic [7:0]          mem_be_o;
  logic                mem_rvalid_i = 1'b0;
  logic [63:0]         mem_rdata_i = '0;
`ifdef TAG_ARB_PERF_CNT_EN
  logic [N-1:0][31:0]  grant_cnt_o;
  logic [31:0]         err_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  tag_mem_arbiter #(.NumReq(N)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_we_i(req_we_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
`ifdef TAG_ARB_PERF_CNT_EN
    , .grant_cnt_o(grant_cnt_o), .err_cnt_o(err_cnt_o)
`endif
  );

  // Reference address map: tag bit per 16 B, tag word per KiB, tag store excluded.
  function automatic bit m_inr(input logic [63:0] a);
    if (a < DB) return 0;
    if (a - DB >= TL * 128) return 0;
    if (a >= TB && a - TB < TL) return 0;
    return 1;
  endfunction

  function automatic logic [63:0] m_taddr(input logic [63:0] a);
    return TB + ((a - DB) / 1024) * 8;
  endfunction

  typedef struct {
    int          idx;
    logic        req_t1;
    logic [63:0] maddr;
    logic        mwe;
    logic [63:0] mwdata;
    logic [7:0]  mbe;
    bit          stable;
    logic [N-1:0] rsp;
    logic [63:0] rdata;
    logic        err;
    int          lat;
  } obs_t;

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    rst_ni = 1'b0; req_valid_i = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    repeat (2) cyc();
    rst_ni = 1'b1;
  endtask

  // Drives one single-requester transaction and plays the memory side; records what it saw.
  task automatic run_txn(input int r, input logic [63:0] addr, input logic we,
                         input logic [63:0] wd, input logic [7:0] be,
                         input int gdly, input int rdly, input logic [63:0] rd,
                         output obs_t o);
    int n;
    o = '{default: 0};
    o.idx = -1;
    mem_rdata_i = {$urandom, $urandom};
    req_valid_i[r] = 1'b1; req_addr_i[r] = addr; req_we_i[r] = we;
    req_wdata_i[r] = wd; req_be_i[r] = be;
    #1;
    n = 0;
    while (req_ready_o == '0 && n < 20) begin cyc(); n++; end
    for (int i = 0; i < N; i++) if (req_ready_o[i]) o.idx = i;
    if (n >= 20) begin req_valid_i[r] = 1'b0; return; end
    cyc();
    req_valid_i[r] = 1'b0;
    #1;
    o.req_t1 = mem_req_o;
    if (rsp_valid_o != '0) begin
      o.rsp = rsp_valid_o; o.rdata = rsp_rdata_o; o.err = rsp_err_o; o.lat = 1;
      cyc();
      return;
    end
    o.maddr = mem_addr_o; o.mwe = mem_we_o; o.mwdata = mem_wdata_o; o.mbe = mem_be_o;
    o.stable = 1;
    for (int i = 0; i < gdly; i++) begin
      cyc();
      if (mem_req_o !== 1'b1 || mem_addr_o !== o.maddr || mem_we_o !== o.mwe ||
          mem_wdata_o !== o.mwdata || mem_be_o !== o.mbe) o.stable = 0;
    end
    o.lat = 1 + gdly;
    mem_gnt_i = 1'b1;
    if (rdly == 0) begin
      mem_rvalid_i = 1'b1; mem_rdata_i = rd;
      #1;
      o.rsp = rsp_valid_o; o.rdata = rsp_rdata_o; o.err = rsp_err_o;
      cyc();
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    end else begin
      cyc();
      mem_gnt_i = 1'b0;
      for (int i = 1; i < rdly; i++) cyc();
      mem_rvalid_i = 1'b1; mem_rdata_i = rd;
      #1;
      o.rsp = rsp_valid_o; o.rdata = rsp_rdata_o; o.err = rsp_err_o;
      o.lat += rdly;
      cyc();
      mem_rvalid_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    req_valid_i = 2'b11; req_addr_i[0] = DB; req_addr_i[1] = DB + 64'h400;
    req_we_i = 2'b11; req_wdata_i[0] = 64'hFFFF; req_be_i[0] = 8'hFF;
    cyc(); cyc();
    checks++; if (req_ready_o !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", req_ready_o); end
    checks++; if (rsp_valid_o !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b want 00", rsp_valid_o); end
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", mem_req_o); end
    checks++; if ({mem_addr_o, mem_wdata_o, mem_be_o, mem_we_o, rsp_err_o, rsp_rdata_o} !== '0) begin
      errors++; $display("FAIL reset_outputs addr=%h wdata=%h be=%h", mem_addr_o, mem_wdata_o, mem_be_o); end
`ifdef TAG_ARB_PERF_CNT_EN
    checks++; if (grant_cnt_o !== '0 || err_cnt_o !== '0) begin errors++; $display("FAIL reset_counters got %h/%h want 0", grant_cnt_o, err_cnt_o); end
`endif
    rst_ni = 1'b1;
    #1;
    checks++; if (req_ready_o !== 2'b01) begin errors++; $display("FAIL reset_first_winner got %b want 01", req_ready_o); end
    cyc();
    req_valid_i = '0; req_we_i = '0; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
    cyc();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
  endtask

  task automatic test_read();
    obs_t o;
    run_txn(0, 64'h8000_0400, 1'b0, '0, '0, 1, 1, 64'hDEAD_BEEF, o);
    checks++; if (o.idx !== 0) begin errors++; $display("FAIL read_grant got %0d want 0", o.idx); end
    checks++; if (o.req_t1 !== 1'b1) begin errors++; $display("FAIL read_mem_req got %b want 1", o.req_t1); end
    checks++; if (o.maddr !== TB + 64'h8) begin errors++; $display("FAIL read_addr got %h want %h", o.maddr, TB + 64'h8); end
    checks++; if (o.mwe !== 1'b0) begin errors++; $display("FAIL read_we got %b want 0", o.mwe); end
    checks++; if (o.rsp !== 2'b01 || o.err !== 1'b0) begin errors++; $display("FAIL read_rsp got %b err %b want 01 err 0", o.rsp, o.err); end
    checks++; if (o.rdata !== 64'hDEAD_BEEF) begin errors++; $display("FAIL read_rdata got %h want deadbeef", o.rdata); end
    checks++; if (o.lat !== 3) begin errors++; $display("FAIL read_latency got %0d want 3", o.lat); end
  endtask

  task automatic test_contention();
    int exp_ptr, exp_g, got, n;
    apply_reset();
    exp_ptr = N - 1;
    req_valid_i = 2'b11; req_addr_i[0] = DB + 64'h800; req_addr_i[1] = DB + 64'hC00; req_we_i = '0;
    for (int k = 0; k < 4; k++) begin
      #1;
      n = 0;
      while (req_ready_o == '0 && n < 10) begin cyc(); n++; end
      got = -1;
      for (int i = 0; i < N; i++) if (req_ready_o[i]) got = i;
      exp_g = (exp_ptr + 1) % N;
      exp_ptr = exp_g;
      checks++; if (got !== exp_g) begin errors++; $display("FAIL contention_order[%0d] got %0d want %0d", k, got, exp_g); end
      cyc();
      mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 64'(k);
      #1;
      checks++; if (rsp_valid_o !== 2'(1 << exp_g) || req_ready_o !== 2'b00) begin
        errors++; $display("FAIL contention_rsp[%0d] rsp %b ready %b want rsp %b ready 00", k, rsp_valid_o, req_ready_o, 2'(1 << exp_g)); end
      cyc();
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    end
    req_valid_i = '0;
    cyc();
  endtask

  task automatic test_out_of_range();
    obs_t o;
    logic [63:0] addrs [2];
    addrs[0] = 64'h8080_0000; addrs[1] = TB;
    for (int k = 0; k < 2; k++) begin
      run_txn(1, addrs[k], 1'b0, '0, '0, 0, 0, 64'h55, o);
      checks++; if (o.req_t1 !== 1'b0) begin errors++; $display("FAIL oor_mem_req[%0d] got %b want 0", k, o.req_t1); end
      checks++; if (o.rsp !== 2'b10 || o.err !== 1'b1) begin errors++; $display("FAIL oor_rsp[%0d] got %b err %b want 10 err 1", k, o.rsp, o.err); end
      checks++; if (o.rdata !== '0 || o.lat !== 1) begin errors++; $display("FAIL oor_data_lat[%0d] rdata %h lat %0d want 0 lat 1", k, o.rdata, o.lat); end
    end
  endtask

  task automatic test_write_stall();
    obs_t o;
    run_txn(1, 64'h807F_FC00, 1'b1, 64'h1, 8'h01, 5, 1, 64'h0, o);
    checks++; if (o.maddr !== TB + 64'hFFF8) begin errors++; $display("FAIL wr_addr got %h want %h", o.maddr, TB + 64'hFFF8); end
    checks++; if (o.mwe !== 1'b1 || o.mwdata !== 64'h1 || o.mbe !== 8'h01) begin
      errors++; $display("FAIL wr_fields we %b wdata %h be %h want 1/1/01", o.mwe, o.mwdata, o.mbe); end
    checks++; if (o.stable !== 1'b1) begin errors++; $display("FAIL wr_stable got %0d want 1", o.stable); end
    checks++; if (o.rsp !== 2'b10 || o.err !== 1'b0 || o.lat !== 7) begin
      errors++; $display("FAIL wr_rsp got %b err %b lat %0d want 10 0 7", o.rsp, o.err, o.lat); end
  endtask

  task automatic test_gnt_rvalid_same();
    req_valid_i[0] = 1'b1; req_addr_i[0] = DB; req_we_i[0] = 1'b0;
    #1;
    checks++; if (req_ready_o !== 2'b01) begin errors++; $display("FAIL same_accept got %b want 01", req_ready_o); end
    cyc();
    req_valid_i[0] = 1'b0;
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 64'h1234;
    req_valid_i[1] = 1'b1; req_addr_i[1] = 64'h1000;
    #1;
    checks++; if (rsp_valid_o !== 2'b01 || rsp_rdata_o !== 64'h1234 || rsp_err_o !== 1'b0) begin
      errors++; $display("FAIL same_rsp got %b %h err %b want 01 1234 0", rsp_valid_o, rsp_rdata_o, rsp_err_o); end
    checks++; if (req_ready_o !== 2'b00) begin errors++; $display("FAIL same_no_grant got %b want 00", req_ready_o); end
    cyc();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    #1;
    checks++; if (req_ready_o !== 2'b10) begin errors++; $display("FAIL same_idle_next got %b want 10", req_ready_o); end
    cyc();
    req_valid_i[1] = 1'b0;
    #1;
    checks++; if (rsp_valid_o !== 2'b10 || rsp_err_o !== 1'b1) begin errors++; $display("FAIL same_err got %b err %b want 10 1", rsp_valid_o, rsp_err_o); end
    cyc();
  endtask

  task automatic test_reset_mid();
    req_valid_i[0] = 1'b1; req_addr_i[0] = DB + 64'h2000; req_we_i[0] = 1'b0;
    #1;
    cyc();
    req_valid_i[0] = 1'b0; mem_gnt_i = 1'b1;
    cyc();
    mem_gnt_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    checks++; if (rsp_valid_o !== 2'b00) begin errors++; $display("FAIL rstmid_rsp_wait got %b want 00", rsp_valid_o); end
    cyc();
    mem_rvalid_i = 1'b1; mem_rdata_i = 64'hBAD;
    #1;
    checks++; if (rsp_valid_o !== 2'b00 || rsp_rdata_o !== '0 || mem_req_o !== 1'b0) begin
      errors++; $display("FAIL rstmid_late_rvalid rsp %b rdata %h req %b want 00 0 0", rsp_valid_o, rsp_rdata_o, mem_req_o); end
    cyc();
    mem_rvalid_i = 1'b0; rst_ni = 1'b1;
`ifdef TAG_ARB_PERF_CNT_EN
    checks++; if (grant_cnt_o !== '0) begin errors++; $display("FAIL rstmid_cnt_clear got %h want 0", grant_cnt_o); end
`endif
    req_valid_i = 2'b11; req_addr_i[1] = DB + 64'h3000; req_we_i = '0;
    #1;
    checks++; if (req_ready_o !== 2'b01) begin errors++; $display("FAIL rstmid_ptr got %b want 01", req_ready_o); end
    cyc();
    req_valid_i = '0; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
    #1;
    checks++; if (rsp_valid_o !== 2'b01) begin errors++; $display("FAIL rstmid_resume got %b want 01", rsp_valid_o); end
    cyc();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
`ifdef TAG_ARB_PERF_CNT_EN
    checks++; if (grant_cnt_o[0] !== 32'd1 || grant_cnt_o[1] !== 32'd0) begin
      errors++; $display("FAIL rstmid_cnt got %0d/%0d want 1/0", grant_cnt_o[0], grant_cnt_o[1]); end
`endif
  endtask

  task automatic test_random();
    obs_t o;
    int r, cat, g, rd, lat_exp;
    logic [63:0] a, wd, rdat;
    logic we;
    logic [7:0] be;
    bit inr;
    for (int k = 0; k < 24; k++) begin
      r = $urandom_range(0, N - 1); cat = $urandom_range(0, 3);
      case (cat)
        0: a = DB + 64'($urandom_range(0, 32'h7F_FFFF));
        1: a = DB + 64'h80_0000 + {32'h0, $urandom};
        2: a = TB + 64'($urandom_range(0, 32'hFFFF));
        default: a = 64'($urandom_range(0, 32'h7FFF_FFFF));
      endcase
      we = 1'($urandom); wd = {$urandom, $urandom}; be = 8'($urandom);
      g = $urandom_range(0, 3); rd = $urandom_range(0, 2); rdat = {$urandom, $urandom};
      inr = m_inr(a);
      lat_exp = inr ? 1 + g + rd : 1;
      run_txn(r, a, we, wd, be, g, rd, rdat, o);
      checks++; if (o.idx !== r || o.rsp !== 2'(1 << r) || o.err !== !inr || o.lat !== lat_exp) begin
        errors++; $display("FAIL rand[%0d] a=%h idx %0d rsp %b err %b lat %0d want %0d %b %b %0d",
                           k, a, o.idx, o.rsp, o.err, o.lat, r, 2'(1 << r), !inr, lat_exp); end
      if (inr) begin
        checks++; if (o.req_t1 !== 1'b1 || o.maddr !== m_taddr(a) || o.mwe !== we || o.mwdata !== wd ||
                      o.mbe !== be || o.stable !== 1'b1 || o.rdata !== rdat) begin
          errors++; $display("FAIL rand_mem[%0d] a=%h maddr %h want %h we %b stable %0d rdata %h want %h",
                             k, a, o.maddr, m_taddr(a), o.mwe, o.stable, o.rdata, rdat); end
      end else begin
        checks++; if (o.req_t1 !== 1'b0 || o.rdata !== '0) begin
          errors++; $display("FAIL rand_err[%0d] a=%h req %b rdata %h want 0 0", k, a, o.req_t1, o.rdata); end
      end
      repeat ($urandom_range(0, 2)) cyc();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read();
    test_contention();
    test_out_of_range();
    test_write_stall();
    test_random();
    test_gnt_rvalid_same();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tag_mem_arbiter.md
Name: tag_mem_arbiter

Overview:
- Shares the single CHERI tag-memory port, carved from the top of DRAM at TagCacheMemBase, between NumReq requesters, e.g. tag cache refill and tag cache writeback.
- Converts a DRAM data physical address into the 64-bit tag-word address that covers it.
- Arbitrates round-robin, keeps one memory transaction outstanding, and routes the response back to the owning requester.
- Requests outside the tag-covered range are rejected with an error and never reach memory.

Parameters:
- NumReq, 2, number of requesters (2..8).
- TagBase, ariane_soc::TagCacheMemBase, byte base of the tag store.
- TagLength, ariane_soc::TagCacheMemLength, byte size of the tag store.
- DataBase, ariane_soc::DRAMBase, first data byte covered by tags.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- req_valid_i  in  NumReq  request valid, one bit per requester.
- req_ready_o  out  NumReq  one-hot accept pulse.
- req_addr_i  in  NumReq x 64  data physical address.
- req_we_i  in  NumReq  1 = write tag word.
- req_wdata_i  in  NumReq x 64  tag word write data.
- req_be_i  in  NumReq x 8  write byte enables.
- rsp_valid_o  out  NumReq  one-hot response pulse.
- rsp_rdata_o  out  64  read data, shared by all requesters.
- rsp_err_o  out  1  out-of-range error, qualified by rsp_valid_o.
- mem_req_o  out  1  memory request.
- mem_gnt_i  in  1  memory grant.
- mem_addr_o  out  64  tag-word byte address, 8-byte aligned.
- mem_we_o  out  1  write enable.
- mem_wdata_o  out  64  write data.
- mem_be_o  out  8  byte enables.
- mem_rvalid_i  in  1  memory response valid; also returned for writes.
- mem_rdata_i  in  64  memory read data.

Behaviour:
- Clocking and reset: clk_i only; reset is synchronous and active-low on rst_ni.
- Reset values:
  - All outputs 0.
  - Round-robin pointer = NumReq-1, so requester 0 wins first.
  - State IDLE.
- Tag granularity: 1 tag bit per 16-byte granule. One 64-bit tag word covers 1 KiB of data.
- CoveredLength = TagLength*128; 8 MiB at defaults.
- Translation: off = addr - DataBase. mem_addr = TagBase + ((off >> 10) << 3).
- Range check:
  - In range iff DataBase <= addr < DataBase+CoveredLength, unsigned 64-bit compare.
  - Any address inside [TagBase, TagBase+TagLength) is out of range.
- Arbitration:
  - In IDLE with any req_valid_i set, grant the first valid requester strictly after the pointer, wrapping modulo NumReq.
  - req_ready_o[g] pulses in that same cycle.
  - The pointer updates to g.
  - Addr, we, wdata, be and the translation result are registered.
- FSM:
  - IDLE: grant and capture as above. Next state is ISSUE if in range, else ERR.
  - ISSUE: mem_req_o=1 and mem_* outputs held stable until mem_gnt_i. On grant go to WAIT.
  - WAIT: on mem_rvalid_i, rsp_valid_o[g]=1 and rsp_rdata_o=mem_rdata_i for 1 cycle, rsp_err_o=0; go to IDLE.
  - ERR: rsp_valid_o[g]=1, rsp_err_o=1, rsp_rdata_o=0 for 1 cycle; go to IDLE.
- Latency:
  - Accept to mem_req_o is 1 cycle.
  - Best case accept to response is 3 cycles (gnt and rvalid each 1 cycle later).
  - Error response arrives 1 cycle after accept.
- Simultaneous events:
  - mem_gnt_i and mem_rvalid_i in the same cycle: the response is taken in that cycle, and the FSM skips WAIT's wait (ISSUE goes straight to IDLE).
  - A new grant is not issued in the response cycle. Minimum request spacing is 1 idle cycle.
- Unsolicited traffic: mem_rvalid_i outside WAIT/ISSUE is ignored. An assertion fires in simulation.
- Requester contract: responses are fire-and-forget with no backpressure. req_valid_i may drop without a grant.
- Reset mid-transaction: FSM returns to IDLE and no response is produced. A late mem_rvalid_i is ignored per the rule above.

Optional Feature:
- Macro TAG_ARB_PERF_CNT_EN.
- When defined:
  - Extra outputs grant_cnt_o [NumReq x 32] and err_cnt_o [32].
  - Per-requester grant counters and a global error counter, saturating at 2^32-1.
  - Reset to 0.
- When undefined: ports and logic absent. Functional behaviour identical.

Decomposition:
- tag_arb_pkg:
  - state enum (IDLE, ISSUE, WAIT, ERR).
  - TagGranuleShift=4, TagWordCoverShift=10.
  - Function tag_addr_f(addr) and function in_range_f(addr).
  - Defaults derived from ariane_soc constants.
- One sub-module, rr_pick: combinational round-robin selector. Inputs valid vector and pointer; outputs one-hot grant and index.

Test Plan:
- Read in range: r0 reads 0x8000_0400, no contention -> mem_addr_o = TagBase+0x8, mem_we_o=0; return mem_rdata_i=0xDEAD_BEEF -> rsp_valid_o=01, rsp_rdata_o=0xDEAD_BEEF, rsp_err_o=0.
- Contention: r0 and r1 hold valid continuously for 4 transactions after reset -> grant order 0,1,0,1; no requester starved.
- Out of range: r1 reads 0x8080_0000 (=DataBase+8 MiB), then reads TagBase -> mem_req_o stays 0; rsp_valid_o=10 with rsp_err_o=1 one cycle after accept, both times.
- Write with stalls: r1 writes wdata=0x1, be=0x01 at 0x807F_FC00; mem_gnt_i delayed 5 cycles -> mem_addr_o=TagBase+0xFFF8 with all mem_* stable while mem_req_o=1.
- Gnt and rvalid together: assert mem_gnt_i and mem_rvalid_i in the same cycle -> response in that cycle; FSM in IDLE the next cycle.
- Reset mid-transaction: rst_ni low during WAIT, then a late mem_rvalid_i -> no rsp_valid_o; pointer back to NumReq-1. With TAG_ARB_PERF_CNT_EN, grant_cnt_o cleared to 0.
